inst_encoder: RTL and testbench

- Instruction encoder: packs decoded fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) into a 32-bit RV32I instruction word.
- Inverse of the immediate extraction done in the decode stage.
- Encoded words go through a 2-entry FIFO into an instruction-memory write port, with an auto-incrementing word address.
- Used by the program loader / self-test sequencer to build instruction memory images in hardware.

---
 rtl/inst_encoder.sv | 192 +++++++++++++++++++
 tb/tb_inst_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Purpose : packs decoded RV32I fields into a 32-bit instruction word and queues it for an imem write port.
// Latency : a bundle accepted at edge N is at the FIFO head (o_WrValid=1) after edge N when the FIFO was empty.
// Backpr. : o_Ready = FIFO not full (2 entries); it does not look at i_WrReady, so nothing passes through when full.
//
// Ports: i_Clk/i_Rst_n clock and async active-low reset; i_Valid/o_Ready field-bundle handshake with
// i_OpCode, i_Rd, i_Rs1, i_Rs2, i_Funct3, i_Funct7, i_Immediate; i_AddrLoad/i_AddrValue reload the write
// address counter; o_WrValid/i_WrReady write handshake with o_WrAddr/o_WrData; o_Error one-cycle
// reject pulse; o_ErrCount saturating reject count.
// Build option: define INST_ENCODER_RANGE_CHECK_EN to reject immediates that do not fit their format.

module inst_encoder_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         push_rdy,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign push_rdy = (count < CW'(DEPTH));
  assign pop_vld  = (count != '0);
  assign pop_dat  = mem[rd_ptr];
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_vld && pop_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module inst_encoder #(
  parameter logic [31:0] P_BASE_ADDR = 32'h0000_0000,
  parameter int          P_ERRCNT_W  = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  input  logic [6:0]            i_OpCode,
  input  logic [4:0]            i_Rd,
  input  logic [4:0]            i_Rs1,
  input  logic [4:0]            i_Rs2,
  input  logic [2:0]            i_Funct3,
  input  logic [6:0]            i_Funct7,
  input  logic [31:0]           i_Immediate,
  input  logic                  i_AddrLoad,
  input  logic [31:0]           i_AddrValue,
  output logic                  o_WrValid,
  input  logic                  i_WrReady,
  output logic [31:0]           o_WrAddr,
  output logic [31:0]           o_WrData,
  output logic                  o_Error,
  output logic [P_ERRCNT_W-1:0] o_ErrCount
);
  logic [31:0]           enc_word;
  logic                  unsupported;
  logic                  reject;
  logic                  push_vld;
  logic                  bad_evt;
  logic [31:0]           addr_q;
  logic                  err_q;
  logic [P_ERRCNT_W-1:0] err_cnt_q;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_L      = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate scatter is the inverse of the decode-stage extraction.
  always_comb begin
    enc_word    = '0;
    unsupported = 1'b0;
    case (i_OpCode)
      OP_R:
        enc_word = {i_Funct7, i_Rs2, i_Rs1, i_Funct3, i_Rd, i_OpCode};
      OP_I, OP_L, OP_JALR:
        enc_word = {i_Immediate[11:0], i_Rs1, i_Funct3, i_Rd, i_OpCode};
      OP_S:
        enc_word = {i_Immediate[11:5], i_Rs2, i_Rs1, i_Funct3, i_Immediate[4:0], i_OpCode};
      OP_B:
        enc_word = {i_Immediate[12], i_Immediate[10:5], i_Rs2, i_Rs1, i_Funct3,
                    i_Immediate[4:1], i_Immediate[11], i_OpCode};
      OP_LUI, OP_AUIPC:
        enc_word = {i_Immediate[31:12], i_Rd, i_OpCode};
      OP_JAL:
        enc_word = {i_Immediate[20], i_Immediate[10:1], i_Immediate[11],
                    i_Immediate[19:12], i_Rd, i_OpCode};
      default:
        unsupported = 1'b1;
    endcase
  end

`ifdef INST_ENCODER_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  logic               range_bad;

  assign imm_s = $signed(i_Immediate);

  always_comb begin
    range_bad = 1'b0;
    case (i_OpCode)
      OP_I, OP_L, OP_JALR, OP_S:
        range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      OP_B:
        range_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || i_Immediate[0];
      OP_JAL:
        range_bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || i_Immediate[0];
      OP_LUI, OP_AUIPC:
        range_bad = (i_Immediate[11:0] != 12'h000);
      default:
        range_bad = 1'b0;
    endcase
  end

  assign reject = unsupported || range_bad;
`else
  assign reject = unsupported;
`endif

  // Rejected bundles still complete the handshake; they just never enter the queue.
  assign push_vld = i_Valid && !reject;
  assign bad_evt  = i_Valid && o_Ready && reject;

  inst_encoder_fifo #(.W(32), .DEPTH(2)) u_fifo (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .push_vld (push_vld),
    .push_dat (enc_word),
    .push_rdy (o_Ready),
    .pop_vld  (o_WrValid),
    .pop_rdy  (i_WrReady),
    .pop_dat  (o_WrData)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      addr_q    <= P_BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      // A load in the same cycle as a transfer overrides the +4 step.
      if (i_AddrLoad)
        addr_q <= {i_AddrValue[31:2], 2'b00};
      else if (o_WrValid && i_WrReady)
        addr_q <= addr_q + 32'd4;
      err_q <= bad_evt;
      if (bad_evt && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + P_ERRCNT_W'(1);
    end
  end

  assign o_WrAddr   = addr_q;
  assign o_Error    = err_q;
  assign o_ErrCount = err_cnt_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Purpose : randomized and directed stimulus for inst_encoder against a field-arithmetic reference model.
// Latency : model tracks the 2-entry queue, write address and error counter edge by edge.
// Backpr. : i_WrReady is toggled to exercise full-queue stalls.

module tb_inst_encoder;
  logic        i_Clk = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_Valid = 1'b0;
  logic        o_Ready;
  logic [6:0]  i_OpCode = '0;
  logic [4:0]  i_Rd = '0;
  logic [4:0]  i_Rs1 = '0;
  logic [4:0]  i_Rs2 = '0;
  logic [2:0]  i_Funct3 = '0;
  logic [6:0]  i_Funct7 = '0;
  logic [31:0] i_Immediate = '0;
  logic        i_AddrLoad = 1'b0;
  logic [31:0] i_AddrValue = '0;
  logic        o_WrValid;
  logic        i_WrReady = 1'b0;
  logic [31:0] o_WrAddr;
  logic [31:0] o_WrData;
  logic        o_Error;
  logic [7:0]  o_ErrCount;

  always #5 i_Clk = ~i_Clk;

  inst_encoder #(.P_BASE_ADDR(32'h0000_0000), .P_ERRCNT_W(8)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_OpCode(i_OpCode), .i_Rd(i_Rd), .i_Rs1(i_Rs1), .i_Rs2(i_Rs2),
    .i_Funct3(i_Funct3), .i_Funct7(i_Funct7), .i_Immediate(i_Immediate),
    .i_AddrLoad(i_AddrLoad), .i_AddrValue(i_AddrValue),
    .o_WrValid(o_WrValid), .i_WrReady(i_WrReady), .o_WrAddr(o_WrAddr),
    .o_WrData(o_WrData), .o_Error(o_Error), .o_ErrCount(o_ErrCount)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  bit [31:0] exp_q[$];
  bit [31:0] m_addr;
  bit        m_err;
  int        m_cnt;
  bit [63:0] wr_log[$];

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Builds the word from the format tables with shifts and masks; rej marks bundles that must be dropped.
  function automatic void ref_encode(bit [31:0] op, bit [31:0] rd, bit [31:0] rs1, bit [31:0] rs2,
                                     bit [31:0] f3, bit [31:0] f7, bit [31:0] imm,
                                     output bit [31:0] w, output bit rej);
    int si;
    bit [31:0] base;
    si   = int'(imm);
    base = op | (f3 << 12) | (rs1 << 15);
    w    = 0;
    rej  = 0;
    case (op)
      32'h33: w = base | (rd << 7) | (rs2 << 20) | (f7 << 25);
      32'h13, 32'h03, 32'h67: begin
        w = base | (rd << 7) | ((imm & 32'hFFF) << 20);
`ifdef INST_ENCODER_RANGE_CHECK_EN
        rej = (si < -2048) || (si > 2047);
`endif
      end
      32'h23: begin
        w = base | ((imm & 31) << 7) | (rs2 << 20) | (((imm >> 5) & 127) << 25);
`ifdef INST_ENCODER_RANGE_CHECK_EN
        rej = (si < -2048) || (si > 2047);
`endif
      end
      32'h63: begin
        w = base | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (rs2 << 20)
                 | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
`ifdef INST_ENCODER_RANGE_CHECK_EN
        rej = (si < -4096) || (si > 4094) || (si % 2 != 0);
`endif
      end
      32'h37, 32'h17: begin
        w = op | (rd << 7) | (imm & 32'hFFFF_F000);
`ifdef INST_ENCODER_RANGE_CHECK_EN
        rej = (imm % 4096) != 0;
`endif
      end
      32'h6F: begin
        w = op | (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
               | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
`ifdef INST_ENCODER_RANGE_CHECK_EN
        rej = (si < -1048576) || (si > 1048574) || (si % 2 != 0);
`endif
      end
      default: rej = 1;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_addr = 32'h0;
    m_err  = 0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs(string tag);
    check_eq({tag, "_rdy"}, 32'(o_Ready), 32'(exp_q.size() < 2));
    check_eq({tag, "_wvld"}, 32'(o_WrValid), 32'(exp_q.size() > 0));
    check_eq({tag, "_addr"}, o_WrAddr, m_addr);
    if (exp_q.size() > 0) check_eq({tag, "_data"}, o_WrData, exp_q[0]);
    check_eq({tag, "_err"}, 32'(o_Error), 32'(m_err));
    check_eq({tag, "_ecnt"}, 32'(o_ErrCount), 32'(m_cnt));
  endtask

  // Called at a falling edge with inputs already set; advances one cycle and checks.
  task automatic tick(string tag);
    bit [31:0] w;
    bit rej, has_room, push, pop, bad;
    ref_encode(32'(i_OpCode), 32'(i_Rd), 32'(i_Rs1), 32'(i_Rs2), 32'(i_Funct3),
               32'(i_Funct7), i_Immediate, w, rej);
    has_room = exp_q.size() < 2;
    push = i_Valid && has_room && !rej;
    bad  = i_Valid && has_room && rej;
    pop  = (exp_q.size() > 0) && i_WrReady;
    if (o_WrValid && i_WrReady) wr_log.push_back({o_WrAddr, o_WrData});
    @(posedge i_Clk);
    if (pop) begin
      void'(exp_q.pop_front());
      m_addr = m_addr + 32'd4;
    end
    if (i_AddrLoad) m_addr = {i_AddrValue[31:2], 2'b00};
    if (push) exp_q.push_back(w);
    m_err = bad;
    if (bad && m_cnt < 255) m_cnt++;
    @(negedge i_Clk);
    check_outputs(tag);
  endtask

  task automatic drive(bit [6:0] op, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                       bit [2:0] f3, bit [6:0] f7, bit [31:0] imm);
    i_Valid = 1; i_OpCode = op; i_Rd = rd; i_Rs1 = rs1; i_Rs2 = rs2;
    i_Funct3 = f3; i_Funct7 = f7; i_Immediate = imm;
  endtask

  task automatic do_reset(string tag);
    i_Valid = 0; i_AddrLoad = 0; i_WrReady = 0;
    i_Rst_n = 0;
    model_reset();
    @(negedge i_Clk);
    check_eq({tag, "_rst_wvld"}, 32'(o_WrValid), 32'h0);
    check_eq({tag, "_rst_rdy"}, 32'(o_Ready), 32'h1);
    check_eq({tag, "_rst_data"}, o_WrData, 32'h0);
    check_eq({tag, "_rst_addr"}, o_WrAddr, 32'h0);
    check_eq({tag, "_rst_err"}, 32'(o_Error), 32'h0);
    check_eq({tag, "_rst_ecnt"}, 32'(o_ErrCount), 32'h0);
    i_Rst_n = 1;
  endtask

  bit [6:0] op_tab[11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h7F};

  initial begin
    int base;
    @(negedge i_Clk);
    do_reset("init");

    // ADDI x1,x0,5
    i_WrReady = 1;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick("addi_push");
    i_Valid = 0;
    tick("addi_pop");
    check_eq("addi_log_n", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() >= 1) begin
      check_eq("addi_wa", wr_log[0][63:32], 32'h0);
      check_eq("addi_wd", wr_log[0][31:0], 32'h0050_0093);
    end

    // BEQ / LUI / JAL back to back from a fresh counter
    do_reset("seq");
    i_WrReady = 1;
    base = wr_log.size();
    drive(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);           tick("beq");
    drive(7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);   tick("lui");
    drive(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);        tick("jal");
    i_Valid = 0;
    tick("seq_d0"); tick("seq_d1");
    check_eq("seq_log_n", 32'(wr_log.size() - base), 32'd3);
    if (wr_log.size() - base == 3) begin
      check_eq("beq_wd", wr_log[base][31:0], 32'h0000_0463);
      check_eq("lui_wa", wr_log[base+1][63:32], 32'h4);
      check_eq("lui_wd", wr_log[base+1][31:0], 32'h1234_5137);
      check_eq("jal_wa", wr_log[base+2][63:32], 32'h8);
      check_eq("jal_wd", wr_log[base+2][31:0], 32'h0010_00EF);
    end

    // Backpressure: three bundles against a stalled write port
    i_WrReady = 0;
    base = wr_log.size();
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); tick("bp0");
    drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2); tick("bp1");
    drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3); tick("bp2");
    check_eq("bp_full_rdy", 32'(o_Ready), 32'h0);
    check_eq("bp_hold_wd", o_WrData, 32'h0010_0093);
    i_WrReady = 1;
    tick("bp3");
    tick("bp4");
    i_Valid = 0;
    for (int k = 0; k < 4; k++) tick("bp_drain");
    check_eq("bp_log_n", 32'(wr_log.size() - base), 32'd3);
    if (wr_log.size() - base == 3) begin
      check_eq("bp_wd0", wr_log[base][31:0], 32'h0010_0093);
      check_eq("bp_wd1", wr_log[base+1][31:0], 32'h0020_0113);
      check_eq("bp_wd2", wr_log[base+2][31:0], 32'h0030_0193);
    end

    // Rejections
    do_reset("err");
    i_WrReady = 1;
    base = wr_log.size();
`ifdef INST_ENCODER_RANGE_CHECK_EN
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); tick("err_imm");
    check_eq("err_imm_pulse", 32'(o_Error), 32'h1);
    check_eq("err_imm_cnt", 32'(o_ErrCount), 32'd1);
`endif
    drive(7'h0F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); tick("err_op");
    check_eq("err_op_pulse", 32'(o_Error), 32'h1);
`ifdef INST_ENCODER_RANGE_CHECK_EN
    check_eq("err_op_cnt", 32'(o_ErrCount), 32'd2);
`else
    check_eq("err_op_cnt", 32'(o_ErrCount), 32'd1);
`endif
    i_Valid = 0;
    tick("err_idle");
    check_eq("err_pulse_end", 32'(o_Error), 32'h0);
    check_eq("err_no_write", 32'(wr_log.size() - base), 32'd0);

    // Address load coinciding with a transfer
    do_reset("ald");
    i_WrReady = 1;
    base = wr_log.size();
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); tick("ald0");
    drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2); tick("ald1");
    drive(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    i_AddrLoad = 1; i_AddrValue = 32'h103;
    tick("ald2");
    i_AddrLoad = 0; i_Valid = 0;
    tick("ald3"); tick("ald4");
    check_eq("ald_log_n", 32'(wr_log.size() - base), 32'd3);
    if (wr_log.size() - base == 3) begin
      check_eq("ald_wa1", wr_log[base+1][63:32], 32'h4);
      check_eq("ald_wa2", wr_log[base+2][63:32], 32'h100);
    end

    // Asynchronous reset with two queued writes
    i_WrReady = 0;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7); tick("ar0");
    drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8); tick("ar1");
    i_Valid = 0;
    #2 i_Rst_n = 0;
    #1;
    check_eq("ar_wvld", 32'(o_WrValid), 32'h0);
    check_eq("ar_rdy", 32'(o_Ready), 32'h1);
    check_eq("ar_addr", o_WrAddr, 32'h0);
    model_reset();
    @(negedge i_Clk);
    i_Rst_n = 1;
    i_WrReady = 1;
    base = wr_log.size();
    for (int k = 0; k < 4; k++) tick("ar_post");
    check_eq("ar_no_stale", 32'(wr_log.size() - base), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit [31:0] imm;
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      if ($urandom_range(0, 3) != 0)
        drive(op_tab[$urandom_range(0, 10)], 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), imm);
      else
        i_Valid = 0;
      i_WrReady   = ($urandom_range(0, 2) != 0);
      i_AddrLoad  = ($urandom_range(0, 19) == 0);
      i_AddrValue = $urandom;
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
